hash_msg_feeder: RTL and testbench

- Initiator side of the byte-serial hash core interface: drives message bytes, the M_valid strobe and the 64-bit length counter into the hash core.
- Waits for the core's hash_ready and captures its 32-bit digest.
- Accepts a host byte stream through a small FIFO and returns the digest on a valid/ready output handshake.
- Sits between the host/bus adapter and the hash core.

---
 rtl/hash_feeder_pkg.sv | 15 +
 rtl/hash_byte_fifo.sv | 52 +++++
 rtl/hash_msg_feeder.sv | 193 +++++++++++++++++++
 tb/tb_hash_msg_feeder.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hash_feeder_pkg.sv
// Shared widths and FSM state encoding for the hash message feeder.
package hash_feeder_pkg;

    localparam int unsigned LEN_W    = 64;
    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned DIGEST_W = 32;

    typedef enum logic [1:0] {
        StIdle,
        StStream,
        StWaitHash,
        StOut
    } state_e;

endpackage

// File: rtl/hash_byte_fifo.sv
// Synchronous FIFO with flush; Depth must be a power of two, at least 2.
module hash_byte_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam logic [PtrW:0] PtrOne = {{PtrW{1'b0}}, 1'b1};

    logic [Width-1:0] mem_q [Depth];
    // Pointers carry one extra wrap bit to tell full from empty.
    logic [PtrW:0]    wr_ptr_q, rd_ptr_q;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                     (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    assign data_o  = mem_q[rd_ptr_q[PtrW-1:0]];

    always_ff @(posedge clk_i) begin
        if (push_i && !full_o && !flush_i) begin
            mem_q[wr_ptr_q[PtrW-1:0]] <= data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i && !full_o) begin
                wr_ptr_q <= wr_ptr_q + PtrOne;
            end
            if (pop_i && !empty_o) begin
                rd_ptr_q <= rd_ptr_q + PtrOne;
            end
        end
    end

endmodule

// File: rtl/hash_msg_feeder.sv
// Feeds host bytes to a byte-serial hash core and returns its digest.
// Define HASH_FEEDER_DIGEST_CHECK_EN to add exp_digest_i / digest_match_o.
module hash_msg_feeder
    import hash_feeder_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [LEN_W-1:0]    msg_len_i,
    input  logic                in_valid_i,
    input  logic [BYTE_W-1:0]   in_data_i,
    output logic                in_ready_o,
    output logic                m_valid_o,
    output logic [BYTE_W-1:0]   message_o,
    output logic [LEN_W-1:0]    counter_o,
    input  logic                hash_ready_i,
    input  logic [DIGEST_W-1:0] digest_i,
    output logic                out_valid_o,
    output logic [DIGEST_W-1:0] out_digest_o,
    input  logic                out_ready_i,
`ifdef HASH_FEEDER_DIGEST_CHECK_EN
    input  logic [DIGEST_W-1:0] exp_digest_i,
    output logic                digest_match_o,
`endif
    output logic                busy_o,
    output logic                timeout_err_o
);

    localparam int unsigned WaitW = $clog2(TIMEOUT + 1);

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    bytes_in_q, bytes_in_d;
    logic [LEN_W-1:0]    bytes_sent_q, bytes_sent_d;
    logic [WaitW-1:0]    wait_cnt_q, wait_cnt_d;
    logic                m_valid_q, m_valid_d;
    logic [BYTE_W-1:0]   message_q, message_d;
    logic                out_valid_q, out_valid_d;
    logic [DIGEST_W-1:0] out_digest_q, out_digest_d;
    logic                timeout_err_q, timeout_err_d;

    logic                fifo_flush, fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [BYTE_W-1:0]   fifo_data;

`ifdef HASH_FEEDER_DIGEST_CHECK_EN
    logic [DIGEST_W-1:0] exp_digest_q, exp_digest_d;
    logic                match_q, match_d;
    assign digest_match_o = match_q;
`endif

    hash_byte_fifo #(
        .Depth (FIFO_DEPTH),
        .Width (BYTE_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (fifo_flush),
        .push_i  (fifo_push),
        .data_i  (in_data_i),
        .pop_i   (fifo_pop),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign in_ready_o    = (state_q == StStream) && !fifo_full && (bytes_in_q < len_q);
    assign m_valid_o     = m_valid_q;
    assign message_o     = message_q;
    assign counter_o     = (state_q == StStream || state_q == StWaitHash) ? len_q : '0;
    assign out_valid_o   = out_valid_q;
    assign out_digest_o  = out_digest_q;
    assign busy_o        = (state_q != StIdle);
    assign timeout_err_o = timeout_err_q;

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        bytes_in_d    = bytes_in_q;
        bytes_sent_d  = bytes_sent_q;
        wait_cnt_d    = wait_cnt_q;
        m_valid_d     = 1'b0;
        message_d     = message_q;
        out_valid_d   = out_valid_q;
        out_digest_d  = out_digest_q;
        timeout_err_d = timeout_err_q;
        fifo_flush    = 1'b0;
        fifo_push     = 1'b0;
        fifo_pop      = 1'b0;
`ifdef HASH_FEEDER_DIGEST_CHECK_EN
        exp_digest_d  = exp_digest_q;
        match_d       = match_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    timeout_err_d = 1'b0;
                    fifo_flush    = 1'b1;
                    if (msg_len_i != '0) begin
                        len_d        = msg_len_i;
                        bytes_in_d   = '0;
                        bytes_sent_d = '0;
                        wait_cnt_d   = '0;
                        state_d      = StStream;
`ifdef HASH_FEEDER_DIGEST_CHECK_EN
                        exp_digest_d = exp_digest_i;
`endif
                    end
                end
            end
            StStream: begin
                fifo_push = in_valid_i && in_ready_o;
                if (fifo_push) begin
                    bytes_in_d = bytes_in_q + 64'd1;
                end
                if (!fifo_empty && (bytes_sent_q < len_q)) begin
                    fifo_pop     = 1'b1;
                    m_valid_d    = 1'b1;
                    message_d    = fifo_data;
                    bytes_sent_d = bytes_sent_q + 64'd1;
                    // Leave as the final strobe goes out, not one cycle later.
                    if (bytes_sent_d == len_q) begin
                        state_d = StWaitHash;
                    end
                end
            end
            StWaitHash: begin
                if (hash_ready_i) begin
                    out_digest_d = digest_i;
                    out_valid_d  = 1'b1;
                    state_d      = StOut;
`ifdef HASH_FEEDER_DIGEST_CHECK_EN
                    match_d      = (digest_i == exp_digest_q);
`endif
                end else begin
                    wait_cnt_d = wait_cnt_q + WaitW'(1);
                    if (wait_cnt_d == WaitW'(TIMEOUT)) begin
                        timeout_err_d = 1'b1;
                        fifo_flush    = 1'b1;
                        state_d       = StIdle;
                    end
                end
            end
            StOut: begin
                if (out_ready_i) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
`ifdef HASH_FEEDER_DIGEST_CHECK_EN
                    match_d     = 1'b0;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            len_q         <= '0;
            bytes_in_q    <= '0;
            bytes_sent_q  <= '0;
            wait_cnt_q    <= '0;
            m_valid_q     <= 1'b0;
            message_q     <= '0;
            out_valid_q   <= 1'b0;
            out_digest_q  <= '0;
            timeout_err_q <= 1'b0;
`ifdef HASH_FEEDER_DIGEST_CHECK_EN
            exp_digest_q  <= '0;
            match_q       <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            bytes_in_q    <= bytes_in_d;
            bytes_sent_q  <= bytes_sent_d;
            wait_cnt_q    <= wait_cnt_d;
            m_valid_q     <= m_valid_d;
            message_q     <= message_d;
            out_valid_q   <= out_valid_d;
            out_digest_q  <= out_digest_d;
            timeout_err_q <= timeout_err_d;
`ifdef HASH_FEEDER_DIGEST_CHECK_EN
            exp_digest_q  <= exp_digest_d;
            match_q       <= match_d;
`endif
        end
    end

endmodule

// File: tb/tb_hash_msg_feeder.sv
// Self-checking bench for hash_msg_feeder: vector table plus directed corner sequences.
module tb_hash_msg_feeder;

    localparam int unsigned FifoDepth = 4;
    localparam int unsigned Timeout   = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] msg_len;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        m_valid;
    logic [7:0]  message;
    logic [63:0] counter;
    logic        hash_ready;
    logic [31:0] digest;
    logic        out_valid;
    logic [31:0] out_digest;
    logic        out_ready;
    logic        busy;
    logic        timeout_err;
`ifdef HASH_FEEDER_DIGEST_CHECK_EN
    logic [31:0] exp_digest;
    logic        digest_match;
    logic        exp_match;
`endif

    hash_msg_feeder #(
        .FIFO_DEPTH (FifoDepth),
        .TIMEOUT    (Timeout)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .msg_len_i      (msg_len),
        .in_valid_i     (in_valid),
        .in_data_i      (in_data),
        .in_ready_o     (in_ready),
        .m_valid_o      (m_valid),
        .message_o      (message),
        .counter_o      (counter),
        .hash_ready_i   (hash_ready),
        .digest_i       (digest),
        .out_valid_o    (out_valid),
        .out_digest_o   (out_digest),
        .out_ready_i    (out_ready),
`ifdef HASH_FEEDER_DIGEST_CHECK_EN
        .exp_digest_i   (exp_digest),
        .digest_match_o (digest_match),
`endif
        .busy_o         (busy),
        .timeout_err_o  (timeout_err)
    );

    always #5 clk = ~clk;

    int          pass_cnt  = 0;
    int          total_cnt = 0;
    int          mv_cnt    = 0;
    logic [63:0] cur_len   = 64'd0;
    logic [7:0]  got_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Core-side monitor: records every strobed byte and checks counter alongside it.
    always @(negedge clk) begin
        if (m_valid === 1'b1) begin
            got_q.push_back(message);
            mv_cnt++;
            check("counter_with_m_valid", counter, cur_len);
        end
    end

    task automatic do_start(input logic [63:0] len);
        got_q.delete();
        mv_cnt  = 0;
        cur_len = len;
        start   = 1'b1;
        msg_len = len;
        @(negedge clk); #1;
        start   = 1'b0;
        msg_len = 64'd0;
    endtask

    // Offers up to n_offer bytes until cur_len strobes reach the core; checks in_ready each cycle
    // against an occupancy model (accepted minus strobed bytes).
    task automatic stream(input int n_offer, input logic [63:0] bytes, input bit gaps,
                          input int acc_init, output int acc);
        int idx = 0;
        int cyc = 0;
        logic exp_rdy;
        acc = acc_init;
        while (mv_cnt < int'(cur_len) && cyc < 200) begin
            exp_rdy = ((acc - mv_cnt) < int'(FifoDepth)) && (acc < int'(cur_len));
            check("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
            if (idx < n_offer && (!gaps || $urandom_range(2) != 0)) begin
                in_valid = 1'b1;
                in_data  = (idx < 8) ? bytes[idx*8 +: 8] : 8'hAA;
            end else begin
                in_valid = 1'b0;
            end
            if (in_valid && in_ready) begin
                idx++;
                acc++;
            end
            @(negedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
        if (cyc >= 200) check("stream_cycle_budget", 64'd1, 64'd0);
    endtask

    task automatic finish_hash(input int delay, input logic [31:0] dig, input logic [31:0] exp_dig);
        check("out_valid_before_hash", {63'd0, out_valid}, 64'd0);
        check("busy_in_wait", {63'd0, busy}, 64'd1);
        check("counter_in_wait", counter, cur_len);
        repeat (delay) begin @(negedge clk); #1; end
        hash_ready = 1'b1;
        digest     = dig;
        @(negedge clk); #1;
        hash_ready = 1'b0;
        digest     = 32'h0;
        check("out_valid_after_hash", {63'd0, out_valid}, 64'd1);
        check("out_digest", {32'd0, out_digest}, {32'd0, exp_dig});
        check("counter_in_out", counter, 64'd0);
`ifdef HASH_FEEDER_DIGEST_CHECK_EN
        check("digest_match", {63'd0, digest_match}, {63'd0, exp_match});
`endif
        repeat (3) begin
            @(negedge clk); #1;
            check("out_valid_held", {63'd0, out_valid}, 64'd1);
            check("out_digest_held", {32'd0, out_digest}, {32'd0, exp_dig});
        end
        out_ready = 1'b1;
        @(negedge clk); #1;
        out_ready = 1'b0;
        check("out_valid_after_ready", {63'd0, out_valid}, 64'd0);
        check("busy_after_ready", {63'd0, busy}, 64'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_m_valid"}, {63'd0, m_valid}, 64'd0);
        check({tag, "_message"}, {56'd0, message}, 64'd0);
        check({tag, "_counter"}, counter, 64'd0);
        check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd0);
        check({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
        check({tag, "_out_digest"}, {32'd0, out_digest}, 64'd0);
        check({tag, "_busy"}, {63'd0, busy}, 64'd0);
        check({tag, "_timeout_err"}, {63'd0, timeout_err}, 64'd0);
    endtask

    typedef struct {
        logic [63:0] len;
        int          n_offer;
        logic [63:0] bytes;
        bit          gaps;
        int          delay;
        logic [31:0] dig;
        logic [63:0] exp_bytes;
        logic [31:0] exp_dig;
    } vec_t;

    vec_t vecs[4];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        int acc;
        int n;
        bit ov_seen;

        vecs[0] = '{64'd3, 3, 64'h0000_0000_0033_2211, 1'b0, 5, 32'hDEADBEEF,
                    64'h0000_0000_0033_2211, 32'hDEADBEEF};
        vecs[1] = '{64'd8, 9, 64'h8877_6655_4433_2211, 1'b1, 2, 32'h1234_5678,
                    64'h8877_6655_4433_2211, 32'h1234_5678};
        vecs[2] = '{64'd1, 1, 64'h0000_0000_0000_005A, 1'b0, 0, 32'hCAFE_F00D,
                    64'h0000_0000_0000_005A, 32'hCAFE_F00D};
        vecs[3] = '{64'd4, 4, 64'h0000_0000_A1B2_C3D4, 1'b1, 10, 32'h0BAD_F00D,
                    64'h0000_0000_A1B2_C3D4, 32'h0BAD_F00D};

        rst        = 1'b1;
        start      = 1'b0;
        msg_len    = 64'd0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        hash_ready = 1'b0;
        digest     = 32'h0;
        out_ready  = 1'b0;
`ifdef HASH_FEEDER_DIGEST_CHECK_EN
        exp_digest = 32'h0;
        exp_match  = 1'b0;
`endif
        repeat (2) @(negedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk); #1;

        for (int v = 0; v < 4; v++) begin
            do_start(vecs[v].len);
            stream(vecs[v].n_offer, vecs[v].bytes, vecs[v].gaps, 0, acc);
            check("bytes_accepted", acc, vecs[v].len);
            check("m_valid_count", got_q.size(), vecs[v].len);
            for (int i = 0; i < got_q.size() && i < 8; i++) begin
                check("byte_order", {56'd0, got_q[i]}, {56'd0, vecs[v].exp_bytes[i*8 +: 8]});
            end
            finish_hash(vecs[v].delay, vecs[v].dig, vecs[v].exp_dig);
        end

        // Timeout, then a non-zero start clears the sticky flag.
        do_start(64'd1);
        stream(1, 64'h77, 1'b0, 0, acc);
        n = 0;
        ov_seen = 1'b0;
        while (busy && n < 200) begin
            n++;
            if (out_valid) ov_seen = 1'b1;
            @(negedge clk); #1;
        end
        check("timeout_wait_cycles", n, Timeout);
        check("timeout_err_set", {63'd0, timeout_err}, 64'd1);
        check("timeout_no_out_valid", {63'd0, ov_seen}, 64'd0);
        do_start(64'd1);
        check("timeout_err_cleared_by_start", {63'd0, timeout_err}, 64'd0);
        stream(1, 64'h66, 1'b0, 0, acc);
        check("post_timeout_byte", {56'd0, got_q[0]}, 64'h66);
        finish_hash(1, 32'h0F0F_0F0F, 32'h0F0F_0F0F);

        // Second timeout, cleared by a zero-length start that leaves the core untouched.
        do_start(64'd1);
        stream(1, 64'h55, 1'b0, 0, acc);
        repeat (Timeout) begin @(negedge clk); #1; end
        check("timeout2_err", {63'd0, timeout_err}, 64'd1);
        check("timeout2_idle", {63'd0, busy}, 64'd0);
        do_start(64'd0);
        check("zero_len_clears_err", {63'd0, timeout_err}, 64'd0);
        repeat (4) begin
            @(negedge clk); #1;
            check("zero_len_busy", {63'd0, busy}, 64'd0);
        end
        check("zero_len_no_m_valid", mv_cnt, 64'd0);

        // hash_ready while idle is ignored.
        hash_ready = 1'b1;
        digest     = 32'h1111_2222;
        @(negedge clk); #1;
        hash_ready = 1'b0;
        digest     = 32'h0;
        check("idle_hash_ready_out_valid", {63'd0, out_valid}, 64'd0);
        @(negedge clk); #1;
        check("idle_hash_ready_out_valid2", {63'd0, out_valid}, 64'd0);

        // A start mid-stream changes neither counter nor byte count.
        do_start(64'd2);
        check("mid_in_ready", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        in_data  = 8'h41;
        @(negedge clk); #1;
        in_valid = 1'b0;
        start    = 1'b1;
        msg_len  = 64'd7;
        @(negedge clk); #1;
        start    = 1'b0;
        msg_len  = 64'd0;
        check("mid_start_counter", counter, 64'd2);
        check("mid_start_busy", {63'd0, busy}, 64'd1);
        stream(1, 64'h42, 1'b0, 1, acc);
        check("mid_start_accepted", acc, 64'd2);
        check("mid_start_m_valid_count", mv_cnt, 64'd2);
        if (got_q.size() == 2) begin
            check("mid_start_byte0", {56'd0, got_q[0]}, 64'h41);
            check("mid_start_byte1", {56'd0, got_q[1]}, 64'h42);
        end
        finish_hash(3, 32'h4242_4141, 32'h4242_4141);

        // Asynchronous reset mid-stream, then a clean message.
        do_start(64'd4);
        in_valid = 1'b1;
        in_data  = 8'h01;
        check("rst_seq_ready0", {63'd0, in_ready}, 64'd1);
        @(negedge clk); #1;
        in_data  = 8'h02;
        check("rst_seq_ready1", {63'd0, in_ready}, 64'd1);
        @(negedge clk); #1;
        in_valid = 1'b0;
        check("rst_seq_busy_before", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        #1;
        check_idle_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        #1;
        do_start(64'd2);
        stream(2, 64'hBBAA, 1'b0, 0, acc);
        check("after_rst_accepted", acc, 64'd2);
        check("after_rst_m_valid_count", mv_cnt, 64'd2);
        if (got_q.size() == 2) begin
            check("after_rst_byte0", {56'd0, got_q[0]}, 64'hAA);
            check("after_rst_byte1", {56'd0, got_q[1]}, 64'hBB);
        end
        finish_hash(4, 32'h5555_AAAA, 32'h5555_AAAA);

`ifdef HASH_FEEDER_DIGEST_CHECK_EN
        exp_digest = 32'h0000_ABCD;
        exp_match  = 1'b1;
        do_start(64'd1);
        exp_digest = 32'h0;
        stream(1, 64'h01, 1'b0, 0, acc);
        finish_hash(2, 32'h0000_ABCD, 32'h0000_ABCD);
        check("match_cleared", {63'd0, digest_match}, 64'd0);
        exp_digest = 32'h0000_ABCD;
        exp_match  = 1'b0;
        do_start(64'd1);
        exp_digest = 32'h0;
        stream(1, 64'h02, 1'b0, 0, acc);
        finish_hash(2, 32'h0000_ABCE, 32'h0000_ABCE);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
